// File: rtl/tte_pkg.sv
// Shared types and constants for the truth-table extractor.
// Holds the FSM state encoding, mask geometry and the n_vars clamp helpers.
package tte_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int MAX_VARS   = 4;
  localparam int MASK_W     = 16;
  localparam int N_VARS_MIN = 2;
  localparam int N_VARS_MAX = MAX_VARS;

  function automatic logic [2:0] clamp_n_vars(input logic [2:0] n);
    if (int'(n) < N_VARS_MIN) return 3'(N_VARS_MIN);
    if (int'(n) > N_VARS_MAX) return 3'(N_VARS_MAX);
    return n;
  endfunction

  // Highest vector index of a sweep over n variables: 2^n - 1.
  function automatic logic [3:0] last_index(input logic [2:0] n);
    return 4'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/tte_settle_timer.sv
// Settle down-counter: load arms SETTLE-1, count decrements, expire flags zero.
// Expire is combinational from the count, so a load of 0 expires on the very next cycle.
module tte_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= 4'(SETTLE - 1);
    end else if (count && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign expire = (cnt_q == 4'd0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all 2^n input vectors, captures f_sop into minterm_mask; done pulses in cycle 1+2^n*(SETTLE+1).
// start is ignored while busy or finishing; TTE_POS_CHECK_EN adds SOP/POS mismatch detection.
module truth_table_extractor
  import tte_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        n_vars,
  output logic [3:0]        vec,
  input  logic              f_sop,
  input  logic              f_pos,
  output logic              busy,
  output logic              done,
  output logic [MASK_W-1:0] minterm_mask,
  output logic              mismatch,
  output logic [3:0]        mismatch_idx
);

  state_t state_q, state_d;

  logic [2:0]        n_q;
  logic [3:0]        index_q;
  logic [MASK_W-1:0] mask_q;

  logic timer_load, timer_count, timer_expire;
  logic accept, sample, at_last;

  assign at_last = (index_q == last_index(n_q));

  tte_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .count  (timer_count),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    accept      = 1'b0;
    sample      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (timer_expire) state_d = SAMPLE;
        else              timer_count = 1'b1;
      end
      SAMPLE: begin
        busy   = 1'b1;
        sample = 1'b1;
        if (at_last) begin
          state_d = FINISH;
        end else begin
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Index saturates at the last vector so it can never wrap back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= 3'(N_VARS_MIN);
      index_q <= 4'd0;
      mask_q  <= '0;
    end else if (accept) begin
      n_q     <= clamp_n_vars(n_vars);
      index_q <= 4'd0;
      mask_q  <= '0;
    end else if (sample) begin
      mask_q[index_q] <= f_sop;
      if (!at_last) index_q <= index_q + 4'd1;
    end
  end

  assign vec          = busy ? index_q : 4'd0;
  assign minterm_mask = mask_q;

`ifdef TTE_POS_CHECK_EN
  logic       mm_q;
  logic [3:0] mm_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_q     <= 1'b0;
      mm_idx_q <= 4'd0;
    end else if (accept) begin
      mm_q     <= 1'b0;
      mm_idx_q <= 4'd0;
    end else if (sample && (f_sop != f_pos) && !mm_q) begin
      mm_q     <= 1'b1;
      mm_idx_q <= index_q;
    end
  end

  assign mismatch     = mm_q;
  assign mismatch_idx = mm_idx_q;
`else
  logic unused_f_pos;
  assign unused_f_pos = f_pos;
  assign mismatch     = 1'b0;
  assign mismatch_idx = 4'd0;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Self-checking bench: directed cases plus random sweeps against a truth-table reference model.
module tb_truth_table_extractor;

  localparam int SETTLE = 1;

  logic        clk, rst, start;
  logic [2:0]  n_vars;
  logic [3:0]  vec;
  logic        f_sop, f_pos, busy, done, mismatch;
  logic [15:0] minterm_mask;
  logic [3:0]  mismatch_idx;

  logic [15:0] tt_sop, tt_pos;

  int compared   = 0;
  int mismatched = 0;

  truth_table_extractor #(.SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_vars       (n_vars),
    .vec          (vec),
    .f_sop        (f_sop),
    .f_pos        (f_pos),
    .busy         (busy),
    .done         (done),
    .minterm_mask (minterm_mask),
    .mismatch     (mismatch),
    .mismatch_idx (mismatch_idx)
  );

  // Function under test modelled as two lookup tables indexed by the driven vector.
  assign f_sop = tt_sop[vec];
  assign f_pos = tt_pos[vec];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int eff_n(input logic [2:0] nv);
    if (nv < 3'd2) return 2;
    if (nv > 3'd4) return 4;
    return int'(nv);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected mask and first-disagreement index derived directly from the tables.
  task automatic model(input int n, output logic [15:0] exp_mask,
                       output logic exp_mm, output logic [3:0] exp_idx);
    exp_mask = 16'h0;
    exp_mm   = 1'b0;
    exp_idx  = 4'd0;
    for (int i = 0; i < (1 << n); i++) begin
      exp_mask[i] = tt_sop[i];
      if (tt_sop[i] != tt_pos[i] && !exp_mm) begin
        exp_mm  = 1'b1;
        exp_idx = 4'(i);
      end
    end
`ifndef TTE_POS_CHECK_EN
    exp_mm  = 1'b0;
    exp_idx = 4'd0;
`endif
  endtask

  task automatic run_sweep(input string tag, input logic [2:0] nv);
    int          n, cyc;
    bit          seen_done, vec_ok;
    logic [15:0] exp_mask;
    logic        exp_mm;
    logic [3:0]  exp_idx;
    n = eff_n(nv);
    model(n, exp_mask, exp_mm, exp_idx);
    @(negedge clk);
    n_vars = nv;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen_done = 0; vec_ok = 1;
    while (!seen_done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && int'(vec) >= (1 << n)) vec_ok = 0;
      if (done) seen_done = 1;
    end
    check({tag, "/done_cycle"}, 32'(cyc + 1), 32'(1 + (1 << n) * (SETTLE + 1)));
    check({tag, "/vec_range"}, 32'(vec_ok), 32'd1);
    check({tag, "/busy_in_finish"}, 32'(busy), 32'd0);
    check({tag, "/vec_in_finish"}, 32'(vec), 32'd0);
    check({tag, "/mask"}, 32'(minterm_mask), 32'(exp_mask));
    check({tag, "/mismatch"}, 32'(mismatch), 32'(exp_mm));
    check({tag, "/mismatch_idx"}, 32'(mismatch_idx), 32'(exp_idx));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "/mask_hold"}, 32'(minterm_mask), 32'(exp_mask));
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_mask;
    logic        exp_mm;
    logic [3:0]  exp_idx;
    int          w, cyc;
    bit          x, y, z;

    rst = 1'b1; start = 1'b0; n_vars = 3'd2;
    tt_sop = 16'h0; tt_pos = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/vec", 32'(vec), 32'd0);
    check("reset/mask", 32'(minterm_mask), 32'd0);
    check("reset/mismatch", 32'(mismatch), 32'd0);
    check("reset/mismatch_idx", 32'(mismatch_idx), 32'd0);
    @(negedge clk) rst = 1'b0;

    // x&~y over {x,y}: true only at index 2.
    tt_sop = 16'h0004; tt_pos = tt_sop;
    run_sweep("n2_xny", 3'd2);
    check("n2_xny/const", 32'(minterm_mask), 32'h0004);

    // Five-term SOP over {x,y,z} evaluated bit by bit.
    tt_sop = 16'h0;
    for (int i = 0; i < 8; i++) begin
      x = i[2]; y = i[1]; z = i[0];
      tt_sop[i] = (!x && !y && !z) || (!x && y && z) || (x && !y && !z) ||
                  (x && !y && z) || (x && y && z);
    end
    tt_pos = tt_sop;
    run_sweep("n3_sop", 3'd3);
    check("n3_sop/const", 32'(minterm_mask), 32'h00B9);

    tt_sop = 16'h0;
    foreach (tt_sop[i]) if (i inside {0, 1, 3, 5, 6, 8, 9, 10, 12, 14, 15}) tt_sop[i] = 1'b1;
    tt_pos = tt_sop;
    run_sweep("n4_list", 3'd4);
    check("n4_list/const", 32'(minterm_mask), 32'hD76B);

    tt_pos = tt_sop ^ 16'h0220;
    run_sweep("n4_pos_flip", 3'd4);
`ifdef TTE_POS_CHECK_EN
    check("n4_pos_flip/const_idx", 32'(mismatch_idx), 32'd5);
`else
    check("n4_pos_flip/const_mm", 32'(mismatch), 32'd0);
`endif

    // n_vars below range clamps to two variables; upper mask bits stay clear.
    tt_sop = 16'hFFFF; tt_pos = tt_sop;
    run_sweep("n0_clamp", 3'd0);
    check("n0_clamp/const", 32'(minterm_mask), 32'h000F);

    // Asynchronous reset mid-sweep, then reset colliding with start.
    tt_sop = 16'h5A5F; tt_pos = tt_sop ^ 16'h0002;
    @(negedge clk); n_vars = 3'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (vec != 4'd3 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("rst/reached_vec3", 32'(w < 100), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst/vec", 32'(vec), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/mask", 32'(minterm_mask), 32'd0);
    check("rst/mismatch", 32'(mismatch), 32'd0);
    check("rst/mismatch_idx", 32'(mismatch_idx), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    check("rst/start_blocked", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_sweep("after_rst", 3'd4);

    // Restart while busy and start held into the FINISH cycle are both ignored.
    tt_sop = 16'h3C96; tt_pos = tt_sop;
    model(4, exp_mask, exp_mm, exp_idx);
    @(negedge clk); n_vars = 3'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 4) start = 1'b1;
      if (cyc == 5) start = 1'b0;
    end
    check("restart/done_cycle", 32'(cyc + 1), 32'd33);
    check("restart/mask", 32'(minterm_mask), 32'(exp_mask));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart/finish_start_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("restart/still_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 6; r++) begin
      tt_sop = 16'($urandom);
      tt_pos = tt_sop;
      if ($urandom_range(0, 1) == 1) tt_pos[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 1) == 1) tt_pos[$urandom_range(0, 15)] ^= 1'b1;
      run_sweep($sformatf("rand%0d", r), 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/truth_table_extractor.md
TRUTH_TABLE_EXTRACTOR -- requirements
Module: truth_table_extractor

Interface
REQ-001 SHALL have parameter SETTLE, default 1, number of cycles each input vector is held before sampling (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, request to begin a sweep.
REQ-005 SHALL have port n_vars, input, 3 bits, number of function variables (2..4).
REQ-006 SHALL have port vec, output, 4 bits, input vector driven to the function under test; bit order {x,y,w,z}, with x the MSB of the active bits.
REQ-007 SHALL have port f_sop, input, 1 bit, function output from the SOP form.
REQ-008 SHALL have port f_pos, input, 1 bit, function output from the POS form.
REQ-009 SHALL have port busy, output, 1 bit, high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse at sweep end.
REQ-011 SHALL have port minterm_mask, output, 16 bits; bit i = f_sop sampled at vector i.
REQ-012 SHALL have port mismatch, output, 1 bit, SOP/POS disagreement seen during the sweep.
REQ-013 SHALL have port mismatch_idx, output, 4 bits, first vector index that disagreed.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FINISH.
REQ-015 In IDLE, start=1 SHALL latch n_vars, clear minterm_mask, mismatch and mismatch_idx, set index=0, and go to DRIVE.
REQ-016 n_vars values 0..1 SHALL clamp to 2; values 5..7 SHALL clamp to 4.
REQ-017 DRIVE SHALL hold vec=index (upper unused bits 0) for SETTLE cycles, then go to SAMPLE.
REQ-018 SAMPLE SHALL write f_sop into minterm_mask[index] for one cycle.
REQ-019 From SAMPLE: if index = 2^n-1, SHALL go to FINISH; otherwise SHALL increment index and return to DRIVE.
REQ-020 FINISH SHALL assert done for exactly one cycle and return to IDLE; vec SHALL return to 0.
REQ-021 Latency: with start sampled at cycle 0, done SHALL be high in cycle 1+2^n*(SETTLE+1); for n=2, SETTLE=1 this is cycle 9.
REQ-022 busy SHALL be high in DRIVE and SAMPLE, and low in IDLE and FINISH.
REQ-023 start SHALL be ignored outside IDLE, including in the FINISH cycle.
REQ-024 minterm_mask bits at index 2^n and above SHALL remain 0.
REQ-025 Results SHALL hold until the next accepted start.
REQ-026 index SHALL never wrap; the sweep ends at 2^n-1.

Reset
REQ-027 rst=1 SHALL immediately force IDLE with vec=0, busy=0, done=0, minterm_mask=0, mismatch=0, mismatch_idx=0, index=0.
REQ-028 rst SHALL take priority over a simultaneous start.
REQ-029 Reset mid-sweep SHALL discard all partial results.

Configuration
REQ-030 Macro TTE_POS_CHECK_EN defined: in SAMPLE, f_sop != f_pos SHALL set mismatch, and mismatch_idx SHALL record the first such index only.
REQ-031 Macro TTE_POS_CHECK_EN undefined: f_pos SHALL be unused, and mismatch and mismatch_idx SHALL be tied 0; the port list is unchanged.

Structure
REQ-032 Package tte_pkg SHALL hold the state enum, MAX_VARS=4, MASK_W=16 and the n_vars clamp constants.
REQ-033 The SETTLE down-counter SHALL be sub-module tte_settle_timer (load, count, expire); everything else stays in the top level.

Verification
REQ-034 n_vars=2, SETTLE=1, f_sop=f_pos=x&~y -> minterm_mask=16'h0004, mismatch=0, done in cycle 9.
REQ-035 n_vars=3, f = ~x~y~z + ~xyz + x~y~z + x~yz + xyz (both forms) -> minterm_mask=16'h00B9, done in cycle 17.
REQ-036 n_vars=4, f true at indices 0,1,3,5,6,8,9,10,12,14,15 -> minterm_mask=16'hD76B, done in cycle 33.
REQ-037 n_vars=4, f_pos inverted at indices 5 and 9, macro defined -> mismatch=1, mismatch_idx=5; macro undefined -> both outputs 0.
REQ-038 rst pulsed while vec=3 of an n_vars=4 sweep -> all outputs 0 at once; a new start then completes with a correct mask.
REQ-039 start re-pulsed while busy, and n_vars=7 -> second start ignored; sweep runs 16 vectors with done in cycle 33.
